// File: rtl/MAC32_top.sv
// Combinational fused multiply-add: Result_o = A_i + B_i * C_i, rounded once
// (round-to-nearest-even). Handles zeros, subnormals, infinities and NaNs.
module MAC32_top #(
  parameter int unsigned PARM_XLEN = 32,
  parameter int unsigned PARM_EXP  = 8,
  parameter int unsigned PARM_MANT = 23,
  parameter int unsigned PARM_BIAS = 127
) (
  input  logic [PARM_XLEN-1:0] A_i,
  input  logic [PARM_XLEN-1:0] B_i,
  input  logic [PARM_XLEN-1:0] C_i,
  output logic [PARM_XLEN-1:0] Result_o
);

  localparam int unsigned MW = PARM_MANT + 1;  // mantissa with hidden bit
  localparam int unsigned PW = 2 * MW;         // full product width
  localparam int unsigned GW = MW + 3;         // extra low bits kept during alignment
  localparam int unsigned WW = PW + GW;        // aligned operand width
  localparam int unsigned SW = WW + 1;         // sum width incl. carry
  localparam int unsigned EW = PARM_EXP + 5;   // signed working exponent width

  typedef logic signed [EW-1:0] exp_t;

  logic                 sa, sb, sc, sp;
  logic [PARM_EXP-1:0]  ea, eb, ec;
  logic [PARM_MANT-1:0] fa, fb, fc;
  logic                 a_zero, b_zero, c_zero, a_inf, b_inf, c_inf;
  logic                 p_zero, p_inf, any_nan;
  logic [MW-1:0]        ma, mb, mc;
  exp_t                 ea_e, eb_e, ec_e, ep;
  logic [PW-1:0]        mp;

  assign {sa, ea, fa} = A_i;
  assign {sb, eb, fb} = B_i;
  assign {sc, ec, fc} = C_i;
  assign sp = sb ^ sc;

  assign a_zero = (ea == '0) && (fa == '0);
  assign b_zero = (eb == '0) && (fb == '0);
  assign c_zero = (ec == '0) && (fc == '0);
  assign a_inf  = (ea == '1) && (fa == '0);
  assign b_inf  = (eb == '1) && (fb == '0);
  assign c_inf  = (ec == '1) && (fc == '0);
  assign p_zero = b_zero | c_zero;
  assign p_inf  = b_inf | c_inf;
  assign any_nan = ((ea == '1) && (fa != '0)) | ((eb == '1) && (fb != '0)) |
                   ((ec == '1) && (fc != '0)) | (b_inf & c_zero) | (c_inf & b_zero) |
                   (a_inf & p_inf & (sa ^ sp));

  // Subnormals use exponent 1 with a zero hidden bit
  assign ma   = {ea != '0, fa};
  assign mb   = {eb != '0, fb};
  assign mc   = {ec != '0, fc};
  assign ea_e = (ea == '0) ? exp_t'(1) : exp_t'(ea);
  assign eb_e = (eb == '0) ? exp_t'(1) : exp_t'(eb);
  assign ec_e = (ec == '0) ? exp_t'(1) : exp_t'(ec);
  assign ep   = eb_e + ec_e - exp_t'(PARM_BIAS);
  assign mp   = PW'(mb) * PW'(mc);

  logic [WW-1:0] wa, wp, hi, lo, lo_sh, lo_j;
  logic          s_hi, s_lo, eff_sub, sticky_a, sticky_n, r_sign, sub_n, guard, round_up;
  logic          overflow;
  exp_t          ea_al, e_big, e_dif, e_res, e_fin;
  logic [SW-1:0] sum, nrm;
  logic [MW-1:0] kept;
  logic [MW:0]   rnd;
  int            shamt, lead, sh, rs;

  // Align, add, normalise and round; special operands override at the end
  always_comb begin
    wa = {1'b0, ma, {PARM_MANT{1'b0}}, {GW{1'b0}}};
    wp = {mp, {GW{1'b0}}};
    // A zero addend takes the product exponent so nothing gets shifted away
    ea_al = a_zero ? ep : ea_e;
    if (ea_al >= ep) begin
      hi = wa; s_hi = sa; lo = wp; s_lo = sp; e_big = ea_al; e_dif = ea_al - ep;
    end else begin
      hi = wp; s_hi = sp; lo = wa; s_lo = sa; e_big = ep; e_dif = ep - ea_al;
    end
    shamt    = (e_dif > exp_t'(WW)) ? int'(WW) : int'(e_dif);
    lo_sh    = lo >> shamt;
    sticky_a = ((lo_sh << shamt) != lo);
    lo_j     = lo_sh | WW'(sticky_a);

    eff_sub = sa ^ sp;
    if (!eff_sub) begin
      sum = {1'b0, hi} + {1'b0, lo_j}; r_sign = sa;
    end else if (hi >= lo_j) begin
      sum = {1'b0, hi} - {1'b0, lo_j}; r_sign = s_hi;
    end else begin
      sum = {1'b0, lo_j} - {1'b0, hi}; r_sign = s_lo;
    end

    lead = 0;
    for (int i = 0; i < int'(SW); i++) begin
      if (sum[i]) lead = i;
    end
    e_res = e_big + exp_t'(lead) - exp_t'(2 * PARM_MANT + GW);

    // Below the normal range the shift stops early and the result goes subnormal
    sh    = int'(WW) - lead;
    sub_n = (e_res < exp_t'(1));
    if (sub_n) sh = sh + int'(e_res) - 1;
    if (sh >= 0) begin
      rs = 0; nrm = sum << sh; sticky_n = 1'b0;
    end else begin
      rs = (-sh > int'(SW)) ? int'(SW) : -sh;
      nrm = sum >> rs;
      sticky_n = ((nrm << rs) != sum);
    end

    kept     = nrm[SW-1 -: MW];
    guard    = nrm[SW-1-MW];
    round_up = guard & ((|nrm[SW-2-MW:0]) | sticky_n | kept[0]);
    rnd      = {1'b0, kept} + {{MW{1'b0}}, round_up};
    if (rnd[MW])    e_fin = e_res + exp_t'(1);
    else if (sub_n) e_fin = rnd[MW-1] ? exp_t'(1) : exp_t'(0);
    else            e_fin = e_res;
    overflow = (e_fin >= exp_t'((1 << PARM_EXP) - 1));

    if (any_nan)          Result_o = {1'b0, {PARM_EXP{1'b1}}, 1'b1, {(PARM_MANT-1){1'b0}}};
    else if (a_inf)       Result_o = A_i;
    else if (p_inf)       Result_o = {sp, {PARM_EXP{1'b1}}, {PARM_MANT{1'b0}}};
    else if (p_zero)      Result_o = a_zero ? {sa & sp, {(PARM_XLEN-1){1'b0}}} : A_i;
    else if (sum == '0)   Result_o = '0;
    else if (overflow)    Result_o = {r_sign, {PARM_EXP{1'b1}}, {PARM_MANT{1'b0}}};
    else                  Result_o = {r_sign, e_fin[PARM_EXP-1:0], rnd[PARM_MANT-1:0]};
  end

endmodule

// File: rtl/mac32_dot_seq.sv
// Dot-product sequencer: loads a bias, folds len B*C pairs into it through a single
// FMA with the accumulator fed back on A, then holds the sum on a valid/ready port.
module mac32_dot_seq #(
  parameter int unsigned PARM_XLEN  = 32,
  parameter int unsigned PARM_EXP   = 8,
  parameter int unsigned PARM_MANT  = 23,
  parameter int unsigned PARM_BIAS  = 127,
  parameter int unsigned PARM_LEN_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [PARM_LEN_W-1:0] len_i,
  input  logic [PARM_XLEN-1:0]  bias_i,
  output logic                  busy_o,
  input  logic                  op_valid_i,
  output logic                  op_ready_o,
  input  logic [PARM_XLEN-1:0]  B_i,
  input  logic [PARM_XLEN-1:0]  C_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [PARM_XLEN-1:0]  Result_o,
  output logic [PARM_LEN_W-1:0] beats_o
);

  typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

  state_e                state_q, state_d;
  logic [PARM_XLEN-1:0]  acc_q, acc_d, mac_res;
  logic [PARM_LEN_W-1:0] cnt_q, cnt_d, beats_q, beats_d;
  logic                  beat;

  MAC32_top #(
    .PARM_XLEN (PARM_XLEN),
    .PARM_EXP  (PARM_EXP),
    .PARM_MANT (PARM_MANT),
    .PARM_BIAS (PARM_BIAS)
  ) u_mac (
    .A_i      (acc_q),
    .B_i      (B_i),
    .C_i      (C_i),
    .Result_o (mac_res)
  );

  assign beat        = op_valid_i & op_ready_o;
  assign busy_o      = (state_q != StIdle);
  assign op_ready_o  = (state_q == StAccum);
  assign res_valid_o = (state_q == StHold);
  assign Result_o    = res_valid_o ? acc_q : '0;
  assign beats_o     = beats_q;

  // Next-state and accumulator/counter updates
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    beats_d = beats_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          acc_d   = bias_i;
          cnt_d   = len_i;
          beats_d = '0;
          state_d = (len_i == '0) ? StHold : StAccum;
        end
      end
      StAccum: begin
        if (beat) begin
          acc_d   = mac_res;
          cnt_d   = cnt_q - 1'b1;
          beats_d = beats_q + 1'b1;
          if (cnt_q == PARM_LEN_W'(1)) state_d = StHold;
        end
      end
      StHold: begin
        // A start arriving with the handshake is dropped on purpose
        if (res_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers, asynchronously cleared
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      beats_q <= beats_d;
    end
  end

endmodule

// File: tb/tb_mac32_dot_seq.sv
// Scoreboard bench for mac32_dot_seq: jobs push expected results, a monitor checks
// every cycle the result port is valid.
module tb_mac32_dot_seq;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i, op_valid_i, res_ready_i;
  logic [7:0]  len_i;
  logic [31:0] bias_i, B_i, C_i;
  logic        busy_o, op_ready_o, res_valid_o;
  logic [31:0] Result_o;
  logic [7:0]  beats_o;

  typedef struct {
    logic [31:0] res;
    logic [7:0]  beats;
  } exp_s;

  exp_s        exp_q[$];
  logic [31:0] job_b[16];
  logic [31:0] job_c[16];
  int          total = 0;
  int          bad   = 0;

  mac32_dot_seq dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .len_i       (len_i),
    .bias_i      (bias_i),
    .busy_o      (busy_o),
    .op_valid_i  (op_valid_i),
    .op_ready_o  (op_ready_o),
    .B_i         (B_i),
    .C_i         (C_i),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready_i),
    .Result_o    (Result_o),
    .beats_o     (beats_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic real pow2(input int k);
    real v = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) v = v * 2.0;
    else        for (int i = 0; i < -k; i++) v = v / 2.0;
    return v;
  endfunction

  function automatic real b2r(input logic [31:0] b);
    real v;
    int  e;
    e = int'(b[30:23]);
    if (e == 0) begin
      v = real'(b[22:0]);
      e = 1;
    end else begin
      v = real'({1'b1, b[22:0]});
    end
    v = v * pow2(e - 150);
    return b[31] ? -v : v;
  endfunction

  // Exact for the values used here (short mantissas, normal range)
  function automatic logic [31:0] r2b(input real v);
    real    a;
    int     e;
    logic   s;
    longint m;
    if (v == 0.0) return 32'h0;
    s = (v < 0.0);
    a = s ? -v : v;
    e = 127;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    m = longint'((a - 1.0) * 8388608.0);
    return {s, e[7:0], m[22:0]};
  endfunction

  // Reference: bias plus the sum of products, in plain real arithmetic
  function automatic logic [31:0] model(input int len, input logic [31:0] bias);
    real acc = b2r(bias);
    for (int i = 0; i < len; i++) acc = acc + b2r(job_b[i]) * b2r(job_c[i]);
    return r2b(acc);
  endfunction

  function automatic logic [31:0] rand_val();
    int k = int'($urandom_range(0, 510)) - 255;
    return r2b(real'(k) / 4.0);
  endfunction

  // Monitor: compares the presented result while valid, pops on handshake
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1 && res_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got %h, expected no result", Result_o);
      end else begin
        check("result", Result_o, exp_q[0].res);
        check("final_beats", 32'(beats_o), 32'(exp_q[0].beats));
        if (res_ready_i) void'(exp_q.pop_front());
      end
    end
  end

  task automatic run_job(input int len, input logic [31:0] bias, input int gap, input int stall,
                         input bit poke, input logic [31:0] want);
    exp_q.push_back('{res: want, beats: 8'(len)});
    start_i = 1'b1;
    len_i   = 8'(len);
    bias_i  = bias;
    tick();
    start_i = 1'b0;
    len_i   = 8'($urandom);
    bias_i  = $urandom;
    check("busy_after_start", 32'(busy_o), 32'd1);
    if (len == 0) begin
      check("zero_len_ready", 32'(op_ready_o), 32'd0);
      check("zero_len_hold", 32'(res_valid_o), 32'd1);
    end
    for (int i = 0; i < len; i++) begin
      for (int g = 0; g < gap; g++) begin
        op_valid_i = 1'b0;
        B_i = $urandom;
        C_i = $urandom;
        tick();
        check("beats_in_gap", 32'(beats_o), 32'(i));
      end
      op_valid_i = 1'b1;
      B_i = job_b[i];
      C_i = job_c[i];
      if (poke && i == 0) begin
        start_i = 1'b1; len_i = 8'd5; bias_i = 32'h42000000;
      end
      check("op_ready", 32'(op_ready_o), 32'd1);
      tick();
      start_i    = 1'b0;
      op_valid_i = 1'b0;
      check("beats", 32'(beats_o), 32'(i + 1));
    end
    check("res_valid_next", 32'(res_valid_o), 32'd1);
    check("ready_in_hold", 32'(op_ready_o), 32'd0);
    // Stall the result port while driving junk operands that must be ignored
    for (int s = 0; s < stall; s++) begin
      op_valid_i = 1'b1;
      B_i = $urandom;
      C_i = $urandom;
      if (poke) begin start_i = 1'b1; len_i = 8'd2; bias_i = 32'h3F800000; end
      tick();
    end
    op_valid_i  = 1'b0;
    res_ready_i = 1'b1;
    if (poke) begin start_i = 1'b1; len_i = 8'd3; bias_i = 32'h40000000; end
    tick();
    res_ready_i = 1'b0;
    start_i     = 1'b0;
    check("valid_drop", 32'(res_valid_o), 32'd0);
    check("idle_after", 32'(busy_o), 32'd0);
    if (poke) begin
      repeat (3) tick();
      check("no_second_job_busy", 32'(busy_o), 32'd0);
      check("no_second_job_valid", 32'(res_valid_o), 32'd0);
    end
  endtask

  initial begin
    int          rlen;
    logic [31:0] rbias;
    rst_ni = 1'b1; start_i = 1'b0; op_valid_i = 1'b0; res_ready_i = 1'b0;
    len_i = '0; bias_i = '0; B_i = '0; C_i = '0;
    #1 rst_ni = 1'b0;
    #1;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_ready", 32'(op_ready_o), 32'd0);
    check("rst_valid", 32'(res_valid_o), 32'd0);
    check("rst_result", Result_o, 32'd0);
    check("rst_beats", 32'(beats_o), 32'd0);
    tick();
    rst_ni = 1'b1;
    tick();

    // Single pair: 1.5 + 2*3 = 7.5
    job_b[0] = 32'h40000000; job_c[0] = 32'h40400000;
    run_job(1, 32'h3FC00000, 0, 0, 1'b0, 32'h40F00000);

    // Three pairs: 0 + 1 + 4 + 9 = 14
    job_b[0] = 32'h3F800000; job_c[0] = 32'h3F800000;
    job_b[1] = 32'h40000000; job_c[1] = 32'h40000000;
    job_b[2] = 32'h40400000; job_c[2] = 32'h40400000;
    run_job(3, 32'h00000000, 0, 0, 1'b0, 32'h41600000);
    run_job(3, 32'h00000000, 3, 0, 1'b0, 32'h41600000);
    run_job(3, 32'h00000000, 0, 5, 1'b0, 32'h41600000);
    run_job(3, 32'h00000000, 1, 2, 1'b1, 32'h41600000);

    // Zero length passes the bias straight through
    run_job(0, 32'h40490FDB, 0, 2, 1'b0, 32'h40490FDB);

    // Reset in the middle of a three-pair job
    start_i = 1'b1; len_i = 8'd3; bias_i = 32'h3F800000;
    tick();
    start_i = 1'b0;
    op_valid_i = 1'b1; B_i = 32'h40000000; C_i = 32'h40000000;
    tick();
    op_valid_i = 1'b0;
    check("mid_beats", 32'(beats_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    check("mid_rst_ready", 32'(op_ready_o), 32'd0);
    check("mid_rst_valid", 32'(res_valid_o), 32'd0);
    check("mid_rst_result", Result_o, 32'd0);
    check("mid_rst_beats", 32'(beats_o), 32'd0);
    tick();
    rst_ni = 1'b1;
    tick();
    run_job(3, 32'h00000000, 0, 1, 1'b0, 32'h41600000);

    // Randomised jobs against the real-arithmetic reference
    for (int j = 0; j < 20; j++) begin
      rlen  = int'($urandom_range(0, 8));
      rbias = rand_val();
      for (int i = 0; i < rlen; i++) begin
        job_b[i] = rand_val();
        job_c[i] = rand_val();
      end
      run_job(rlen, rbias, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
              1'b0, model(rlen, rbias));
    end

    repeat (3) tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
